// File: rtl/imem_responder.sv
// Instruction-memory responder: a word-addressed fetch memory with a
// fixed-latency read pipeline that feeds an in-order response FIFO.
// The registered in-flight and queued counts throttle request acceptance,
// so the FIFO always has a slot for every accepted request.
module imem_responder #(
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic [31:0] o_rsp_addr,
    output logic        o_rsp_err,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_addr,
    input  logic [31:0] i_wr_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    // The FIFO write is the last of LATENCY registers, so the pipeline
    // proper holds one stage fewer.
    localparam int P = LATENCY - 1;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [CW:0] FIFO_DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_addr [FIFO_DEPTH];
    logic          fifo_err  [FIFO_DEPTH];

    logic [FW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [CW-1:0] inflight_q, inflight_d;

    logic          accept, deq, acc_err;
    logic [AW-1:0] acc_idx, wr_idx;
    logic          wr_in_range;
    logic          enq_valid, enq_err;
    logic [31:0]   enq_data, enq_addr;
    logic          wr_addr_lsb_unused;

    assign acc_idx     = i_req_addr[AW+1:2];
    assign acc_err     = (i_req_addr[1:0] != 2'b00) || (i_req_addr[31:AW+2] != '0);
    assign wr_idx      = i_wr_addr[AW+1:2];
    assign wr_in_range = (i_wr_addr[31:AW+2] == '0);
    assign wr_addr_lsb_unused = ^i_wr_addr[1:0];

    // Ready depends only on registered counts (and reset), never on i_req_valid
    assign o_req_ready = !i_rst &&
                         (({1'b0, inflight_q} + {1'b0, fifo_count_q}) < FIFO_DEPTH_W);
    assign accept      = i_req_valid && o_req_ready;

    // Preload port; out-of-range writes fall away, memory survives reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_wr_en && wr_in_range) begin
            mem[wr_idx] <= i_wr_data;
        end
    end

    generate
        if (P == 0) begin : g_direct
            // Single-cycle latency: the accepted request goes straight into the FIFO
            assign enq_valid = accept;
            assign enq_addr  = i_req_addr;
            assign enq_err   = acc_err;
            assign enq_data  = mem[acc_idx];
        end else begin : g_pipe
            logic        pipe_valid [P];
            logic        pipe_err   [P];
            logic [31:0] pipe_addr  [P];
            logic [31:0] pipe_data  [P];

            for (genvar gi = 0; gi < P; gi++) begin : g_stage
                logic        valid_q, valid_d, err_q, err_d;
                logic [31:0] addr_q, addr_d, data_q;

                if (gi == 0) begin : g_head
                    // Stage 0 takes the accepted request
                    always_comb begin
                        valid_d = accept;
                        err_d   = acc_err;
                        addr_d  = i_req_addr;
                    end
                    // Registered array read; skipped for faulting requests
                    always_ff @(posedge i_clk) begin
                        if (accept && !acc_err) begin
                            data_q <= mem[acc_idx];
                        end
                    end
                end else begin : g_tail
                    logic [31:0] data_d;
                    // Later stages shift the previous stage forward
                    always_comb begin
                        valid_d = pipe_valid[gi-1];
                        err_d   = pipe_err[gi-1];
                        addr_d  = pipe_addr[gi-1];
                        data_d  = pipe_data[gi-1];
                    end
                    // Data word delay register
                    always_ff @(posedge i_clk) begin
                        data_q <= data_d;
                    end
                end

                // Stage tag registers: valid cleared by reset, payload free-running
                always_ff @(posedge i_clk) begin
                    if (i_rst) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= valid_d;
                    end
                    err_q  <= err_d;
                    addr_q <= addr_d;
                end

                assign pipe_valid[gi] = valid_q;
                assign pipe_err[gi]   = err_q;
                assign pipe_addr[gi]  = addr_q;
                assign pipe_data[gi]  = data_q;
            end

            assign enq_valid = pipe_valid[P-1];
            assign enq_err   = pipe_err[P-1];
            assign enq_addr  = pipe_addr[P-1];
            assign enq_data  = pipe_data[P-1];
        end
    endgenerate

    assign o_rsp_valid = !i_rst && (wr_ptr_q != rd_ptr_q);
    assign deq         = o_rsp_valid && i_rsp_ready;

    // Next-state pointers and counts; simultaneous +1/-1 events net out
    always_comb begin
        wr_ptr_d     = wr_ptr_q + (FW+1)'(enq_valid);
        rd_ptr_d     = rd_ptr_q + (FW+1)'(deq);
        fifo_count_d = fifo_count_q + CW'(enq_valid) - CW'(deq);
        inflight_d   = inflight_q + CW'(accept) - CW'(enq_valid);
    end

    // FIFO storage write; faulting requests carry a NOP instead of memory data
    always_ff @(posedge i_clk) begin
        if (!i_rst && enq_valid) begin
            fifo_data[wr_ptr_q[FW-1:0]] <= enq_err ? NOP_WORD : enq_data;
            fifo_addr[wr_ptr_q[FW-1:0]] <= enq_addr;
            fifo_err[wr_ptr_q[FW-1:0]]  <= enq_err;
        end
    end

    // Pointer and count registers; reset drops everything queued or in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            inflight_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
        end
    end

    assign o_rsp_rdata = o_rsp_valid ? fifo_data[rd_ptr_q[FW-1:0]] : '0;
    assign o_rsp_addr  = o_rsp_valid ? fifo_addr[rd_ptr_q[FW-1:0]] : '0;
    assign o_rsp_err   = o_rsp_valid ? fifo_err[rd_ptr_q[FW-1:0]]  : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Directed and randomised checks for imem_responder (DEPTH=256, LATENCY=2,
// FIFO_DEPTH=4).
module tb_imem_responder;
    localparam int DEPTH      = 256;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata, rsp_addr;
    logic        rsp_err;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    always #5 clk = ~clk;

    imem_responder #(
        .DEPTH(DEPTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_addr(rsp_addr), .o_rsp_err(rsp_err),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t vecs [10];

    logic [31:0] bp_addr [5];
    logic [31:0] bp_data [5];
    logic [64:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result {err, data} for a request address
    function automatic logic [32:0] model(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        if (a[1:0] != 2'b00 || a >= 32'(4*DEPTH)) return {1'b1, 32'h0000_0013};
        return {1'b0, mdl[idx]};
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] idx;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        idx = a[9:2];
        if (a < 32'(4*DEPTH)) mdl[idx] = d;
    endtask

    // Wait (bounded) for a response with rsp_ready=1, capture it, pass the dequeue edge
    task automatic get_rsp(output logic [31:0] d, output logic [31:0] a,
                           output logic e, output int lat);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("rsp_arrival", 32'(rsp_valid), 32'd1);
        d = rsp_rdata; a = rsp_addr; e = rsp_err; lat = n;
        step();
    endtask

    task automatic single(input string name, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d, ra;
        logic e;
        int lat;
        req_valid = 1'b1; req_addr = a;
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        get_rsp(d, ra, e, lat);
        chk({name, "_lat"}, 32'(lat), 32'(LATENCY - 1));
        chk({name, "_data"}, d, exp_d);
        chk({name, "_addr"}, ra, a);
        chk({name, "_err"}, 32'(e), 32'(exp_e));
        $display("txn %s addr=%h data=%h err=%0d", name, a, d, e);
    endtask

    task automatic seq_back_to_back();
        req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
        step();
        req_addr = 32'h4;
        chk("b2b_c1_valid", 32'(rsp_valid), 32'd0);
        step();
        req_addr = 32'h8;
        chk("b2b_c2_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_c2_data", rsp_rdata, 32'h11);
        chk("b2b_c2_err", 32'(rsp_err), 32'd0);
        step();
        req_valid = 1'b0;
        chk("b2b_c3_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_c3_data", rsp_rdata, 32'h22);
        step();
        chk("b2b_c4_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_c4_data", rsp_rdata, 32'h33);
        step();
        chk("b2b_c5_valid", 32'(rsp_valid), 32'd0);
        $display("txn back_to_back 0x0,0x4,0x8 done");
    endtask

    task automatic seq_backpressure();
        int acc, got;
        logic r;
        acc = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = bp_addr[0];
        for (int c = 0; c < 8; c++) begin
            r = req_ready;
            step();
            if (r) begin
                acc++;
                if (acc < 5) req_addr = bp_addr[acc];
            end
        end
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_data", rsp_rdata, 32'h11);
            chk("bp_hold_addr", rsp_addr, 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        chk("bp_ready_at_deq", 32'(req_ready), 32'd0);
        chk("bp_rsp0", rsp_rdata, bp_data[0]);
        step();
        chk("bp_ready_after_deq", 32'(req_ready), 32'd1);
        chk("bp_rsp1", rsp_rdata, bp_data[1]);
        step();
        req_valid = 1'b0;
        got = 2;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (rsp_valid) begin
                chk("bp_rsp_data", rsp_rdata, bp_data[got]);
                chk("bp_rsp_addr", rsp_addr, bp_addr[got]);
                got++;
            end
            step();
        end
        chk("bp_count", 32'(got), 32'd5);
        $display("txn backpressure accepted=%0d responses=%0d", acc, got);
    endtask

    task automatic seq_collision();
        logic [31:0] d, ra;
        logic e;
        int lat;
        wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 32'h8;
        chk("col_ready", 32'(req_ready), 32'd1);
        step();
        wr_en = 1'b0; req_valid = 1'b0;
        mdl[2] = 32'hDEAD_BEEF;
        get_rsp(d, ra, e, lat);
        chk("col_old_data", d, 32'h33);
        $display("txn collision read 0x8 data=%h", d);
        single("col_new", 32'h8, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic seq_reset();
        int seen;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = 32'(4 * k);
            step();
        end
        chk("rst_pre_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 32'h0; wr_data = 32'hBAAD_F00D;
        #1;
        chk("rst_valid_now", 32'(rsp_valid), 32'd0);
        chk("rst_ready_now", 32'(req_ready), 32'd0);
        step();
        chk("rst_valid_next", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        step();
        rst = 1'b0; req_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("rst_ready_release", 32'(req_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("rst_no_stale", 32'(seen), 32'd0);
        $display("txn reset mid-traffic stale=%0d", seen);
        single("rst_mem0", 32'h0, 32'h11, 1'b0);
        single("rst_memC", 32'hC, 32'h44, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        if (r == 7) return {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        if (r == 8) return 32'h400 + 32'(4 * $urandom_range(0, 1000));
        return 32'hFFFF_FFF0;
    endfunction

    task automatic seq_random();
        int sent, recv, outstanding, cyc;
        logic a_acc, d_deq;
        logic [64:0] e;
        logic [32:0] m;
        sent = 0; recv = 0; outstanding = 0; cyc = 0;
        exp_q.delete();
        req_valid = 1'b1; req_addr = rand_addr(); rsp_ready = 1'b0;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            a_acc = req_valid && req_ready;
            d_deq = rsp_valid && rsp_ready;
            chk("rnd_ready", 32'(req_ready), 32'(outstanding < FIFO_DEPTH));
            if (d_deq) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_data", rsp_rdata, e[31:0]);
                    chk("rnd_addr", rsp_addr, e[63:32]);
                    chk("rnd_err", 32'(rsp_err), 32'(e[64]));
                    $display("txn rnd %0d addr=%h data=%h err=%0d", recv, rsp_addr, rsp_rdata, rsp_err);
                    recv++;
                end
            end
            if (a_acc) begin
                m = model(req_addr);
                exp_q.push_back({m[32], req_addr, m[31:0]});
                sent++;
            end
            outstanding = outstanding + int'(a_acc) - int'(d_deq);
            if (outstanding > FIFO_DEPTH) chk("rnd_bound", 32'(outstanding), 32'(FIFO_DEPTH));
            step();
            cyc++;
            if (!req_valid || a_acc) begin
                req_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
                req_addr = rand_addr();
            end
            rsp_ready = (sent >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        req_valid = 1'b0;
        chk("rnd_received", 32'(recv), 32'd1000);
        chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rnd_no_extra", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0011, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h0000_0022, 1'b0};
        vecs[2] = '{32'h0000_000C, 32'h0000_0044, 1'b0};
        vecs[3] = '{32'h0000_03FC, 32'h10FF_00FF, 1'b0};
        vecs[4] = '{32'h0000_0002, 32'h0000_0013, 1'b1};
        vecs[5] = '{32'h0000_0001, 32'h0000_0013, 1'b1};
        vecs[6] = '{32'h0000_0400, 32'h0000_0013, 1'b1};
        vecs[7] = '{32'h0000_0403, 32'h0000_0013, 1'b1};
        vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};
        vecs[9] = '{32'h0000_0010, 32'h0000_0055, 1'b0};
        bp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        bp_data = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

        // Reset state
        step();
        step();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_addr", rsp_addr, 32'h0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("release_ready", 32'(req_ready), 32'd1);

        // Preload: words 0..4 are 0x11..0x55, the rest a recognisable pattern
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 5) wr(32'(4 * i), 32'((i + 1) * 32'h11));
            else       wr(32'(4 * i), 32'h1000_0000 + 32'(i) * 32'h0001_0001);
        end
        wr(32'h400, 32'hBAD0_BAD0);   // out of range, must not alias word 0

        for (int v = 0; v < 10; v++) begin
            single($sformatf("vec%0d", v), vecs[v].addr, vecs[v].rdata, vecs[v].err);
        end

        seq_back_to_back();
        seq_backpressure();
        seq_collision();
        seq_reset();
        seq_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "simulation time limit");
    end
endmodule
